lsu_mem_stage: RTL and testbench

//  Memory-access stage downstream of ALU_top: takes ALU_Result as effective address, RS2 as store

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_extend.sv | 30 +++
 rtl/lsu_mem_stage.sv | 121 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: funct3 codes, FSM states, access sizing.
package lsu_pkg;

  localparam int XLEN      = 64;
  localparam int MEM_BYTES = 8;
  localparam int OFF_W     = $clog2(MEM_BYTES);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 4'd1;
      F3_H, F3_HU: return 4'd2;
      F3_W, F3_WU: return 4'd4;
      default:     return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load lane alignment: shifts the addressed bytes of a memory beat down to bit 0,
// truncates to the access size and sign- or zero-extends to XLEN.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0]  i_beat,
  input  logic [OFF_W-1:0] i_off,
  input  logic [2:0]       i_funct3,
  output logic [XLEN-1:0]  o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_beat >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      F3_B:    o_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_D:    o_data = w_shifted;
      F3_BU:   o_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      F3_WU:   o_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: runs one load/store per request on a valid/ready memory port,
// places store lanes and strobes, and returns extended load data to write-back.
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata
);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;

  logic            w_legal;
  logic            w_aligned;
  logic [7:0]      w_lane_mask;
  logic [XLEN-1:0] w_load_data;

  // Stores only have B/H/W/D; loads add the unsigned variants except a 64-bit one.
  assign w_legal   = req_we ? (req_funct3[2] == 1'b0) : (req_funct3 != 3'b111);
  assign w_aligned = (({1'b0, req_addr[OFF_W-1:0]} & (size_bytes(req_funct3) - 4'd1)) == 4'd0);

  always_comb begin
    case (size_bytes(r_funct3))
      4'd1:    w_lane_mask = 8'h01;
      4'd2:    w_lane_mask = 8'h03;
      4'd4:    w_lane_mask = 8'h0F;
      default: w_lane_mask = 8'hFF;
    endcase
  end

  lsu_load_extend u_load_extend (
    .i_beat   (mem_resp_rdata),
    .i_off    (r_addr[OFF_W-1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (req_valid) w_state_next = (w_legal && w_aligned) ? REQ : ERR;
      REQ:       if (mem_req_ready) w_state_next = WAIT;
      WAIT:      if (mem_resp_valid) w_state_next = RESP;
      RESP, ERR: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == WAIT && mem_resp_valid) begin
        r_rdata <= r_we ? '0 : w_load_data;
      end
    end
  end

  // Memory-side fields are forced to zero outside REQ so idle/reset values are clean.
  always_comb begin
    req_ready     = (r_state == IDLE);
    busy          = (r_state != IDLE);
    resp_valid    = (r_state == RESP) || (r_state == ERR);
    resp_err      = (r_state == ERR);
    resp_rdata    = (r_state == RESP) ? r_rdata : '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = 8'h00;
    if (r_state == REQ) begin
      mem_req_valid = 1'b1;
      mem_req_we    = r_we;
      mem_req_addr  = {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      mem_req_wdata = r_we ? (r_wdata << {r_addr[OFF_W-1:0], 3'b000}) : '0;
      mem_req_wmask = r_we ? (w_lane_mask << r_addr[OFF_W-1:0]) : 8'h00;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with an inline single-beat memory responder.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  lsu_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .busy           (busy),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_mem_acc = 0;

  logic [63:0] mem_model [0:15];
  logic        last_we;
  logic [63:0] last_addr;
  logic [63:0] last_wdata;
  logic [7:0]  last_mask;
  logic        last_saw_mreq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and emulate memory until the response pulse.
  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input int stall, input logic hold,
                       output logic [63:0] rdata, output logic err, output int lat);
    int          cnt;
    logic [63:0] s_addr;
    logic [63:0] s_wdata;
    logic [7:0]  s_mask;
    logic        s_we;
    chk({name, "/req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    lat = 1;
    cnt = 0;
    s_addr = '0; s_wdata = '0; s_mask = '0; s_we = 1'b0;
    last_saw_mreq = mem_req_valid;
    while (!resp_valid && lat < 40) begin
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      if (hold) chk({name, "/busy_ready"}, {62'd0, busy, req_ready}, 64'd2);
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        n_mem_acc++;
        if (s_we) begin
          for (int b = 0; b < 8; b++)
            if (s_mask[b]) mem_model[s_addr[6:3]][8*b +: 8] = s_wdata[8*b +: 8];
        end else begin
          mem_resp_rdata = mem_model[s_addr[6:3]];
        end
        mem_resp_valid = 1'b1;
      end else if (mem_req_valid) begin
        if (cnt == 0) begin
          s_addr = mem_req_addr; s_wdata = mem_req_wdata;
          s_mask = mem_req_wmask; s_we = mem_req_we;
        end else begin
          chk({name, "/stable_addr"},  mem_req_addr,  s_addr);
          chk({name, "/stable_wdata"}, mem_req_wdata, s_wdata);
          chk({name, "/stable_mask"},  {56'd0, mem_req_wmask}, {56'd0, s_mask});
        end
        if (cnt >= stall) mem_req_ready = 1'b1;
        cnt++;
      end
      @(negedge clk);
      lat++;
    end
    chk({name, "/resp_seen"}, {63'd0, resp_valid}, 64'd1);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    req_valid = 1'b0;
    rdata = resp_rdata;
    err   = resp_err;
    last_we = s_we; last_addr = s_addr; last_wdata = s_wdata; last_mask = s_mask;
    $display("txn %s we=%0b f3=%0d addr=0x%h rdata=0x%016h err=%0b lat=%0d",
             name, we, f3, addr, rdata, err, lat);
    @(negedge clk);
    chk({name, "/pulse_end"}, {62'd0, resp_valid, busy}, 64'd0);
  endtask

  task automatic expect_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] exp_data);
    logic [63:0] d;
    logic        e;
    int          l;
    issue(name, 1'b0, f3, addr, 64'd0, 0, 1'b0, d, e, l);
    chk({name, "/rdata"}, d, exp_data);
    chk({name, "/err"}, {63'd0, e}, 64'd0);
    chk({name, "/lat"}, 64'(l), 64'd3);
  endtask

  task automatic expect_err(input string name, input logic we, input logic [2:0] f3,
                            input logic [63:0] addr);
    logic [63:0] d;
    logic        e;
    int          l;
    int          acc0;
    acc0 = n_mem_acc;
    issue(name, we, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, d, e, l);
    chk({name, "/err"}, {63'd0, e}, 64'd1);
    chk({name, "/rdata"}, d, 64'd0);
    chk({name, "/lat"}, 64'(l), 64'd1);
    chk({name, "/no_mreq"}, {63'd0, last_saw_mreq}, 64'd0);
    chk({name, "/no_mem_acc"}, 64'(n_mem_acc - acc0), 64'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "/req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({name, "/flags"}, {60'd0, busy, resp_valid, resp_err, mem_req_valid}, 64'd0);
    chk({name, "/resp_rdata"}, resp_rdata, 64'd0);
    chk({name, "/mem_addr"}, mem_req_addr, 64'd0);
    chk({name, "/mem_wdata"}, mem_req_wdata, 64'd0);
    chk({name, "/mem_wmask"}, {56'd0, mem_req_wmask}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic        e;
    int          l;
    int          acc0;

    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    last_we = 1'b0; last_addr = '0; last_wdata = '0; last_mask = '0; last_saw_mreq = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Signed byte at offset 3 and unsigned word at offset 4
    mem_model[0] = 64'h0000_0000_8000_0000;
    expect_load("LB_1003", 3'b000, 64'h0000_0000_0000_1003, 64'hFFFF_FFFF_FFFF_FF80);
    mem_model[0] = 64'h89AB_CDEF_0123_4567;
    expect_load("LWU_1004", 3'b110, 64'h1004, 64'h0000_0000_89AB_CDEF);
    expect_load("LW_1004",  3'b010, 64'h1004, 64'hFFFF_FFFF_89AB_CDEF);
    expect_load("LH_1006",  3'b001, 64'h1006, 64'hFFFF_FFFF_FFFF_89AB);
    expect_load("LHU_1002", 3'b101, 64'h1002, 64'h0000_0000_0000_0123);
    expect_load("LBU_1007", 3'b100, 64'h1007, 64'h0000_0000_0000_0089);

    // Halfword store to the top lanes with memory stalling three cycles
    issue("SH_1006", 1'b1, 3'b001, 64'h1006, 64'h0000_0000_0000_BEEF, 3, 1'b0, d, e, l);
    chk("SH_1006/addr",  last_addr,  64'h1000);
    chk("SH_1006/wmask", {56'd0, last_mask}, 64'h00C0);
    chk("SH_1006/wdata", last_wdata, 64'hBEEF_0000_0000_0000);
    chk("SH_1006/we",    {63'd0, last_we}, 64'd1);
    chk("SH_1006/rdata", d, 64'd0);
    chk("SH_1006/err",   {63'd0, e}, 64'd0);
    chk("SH_1006/lat",   64'(l), 64'd6);
    expect_load("LD_1000_merged", 3'b011, 64'h1000, 64'hBEEF_CDEF_0123_4567);

    // Misaligned and illegal encodings never reach memory
    expect_err("LD_mis_1004", 1'b0, 3'b011, 64'h1004);
    expect_err("LOAD_f3_111", 1'b0, 3'b111, 64'h1000);
    expect_err("SW_mis_1002", 1'b1, 3'b010, 64'h1002);
    expect_err("STORE_f3_100", 1'b1, 3'b100, 64'h1000);

    // Reset while waiting on memory; the late response must be dropped
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h1000; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_wait/in_req", {63'd0, mem_req_valid}, 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_wait/in_wait", {62'd0, busy, mem_req_valid}, 64'd2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_idle("rst_wait/after_rst");
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    chk_idle("rst_wait/late_resp");
    @(negedge clk);
    chk_idle("rst_wait/settled");
    $display("txn RST_IN_WAIT late response dropped");
    expect_load("LD_after_rst", 3'b011, 64'h1000, 64'hBEEF_CDEF_0123_4567);

    // req_valid held through busy: one memory access per accept, SD then LD same address
    acc0 = n_mem_acc;
    issue("SD_hold_1008", 1'b1, 3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 0, 1'b1, d, e, l);
    chk("SD_hold_1008/one_acc", 64'(n_mem_acc - acc0), 64'd1);
    chk("SD_hold_1008/wmask", {56'd0, last_mask}, 64'h00FF);
    chk("SD_hold_1008/rdata", d, 64'd0);
    acc0 = n_mem_acc;
    issue("LD_hold_1008", 1'b0, 3'b011, 64'h1008, 64'd0, 0, 1'b1, d, e, l);
    chk("LD_hold_1008/one_acc", 64'(n_mem_acc - acc0), 64'd1);
    chk("LD_hold_1008/rdata", d, 64'h0123_4567_89AB_CDEF);
    chk("LD_hold_1008/err", {63'd0, e}, 64'd0);
    chk("LD_hold_1008/lat", 64'(l), 64'd3);
    @(negedge clk);
    chk_idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
